// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver with an ASCII-hex line parser.
// The parser collects up to four hex digits and commits them as a 16-bit
// word when CR or LF arrives. Any other character raises char_err and
// discards the partial word.
module uart_hex_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        char_err,
  output logic        busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_HALF     = TW'(HALF_BIT);
  localparam logic [TW-1:0] T_LAST     = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_byte;
  logic            r_byte_done;
  logic            r_frame_err;
  logic            r_rx_meta;
  logic            r_rx_sync;

  logic [15:0]     r_sr;
  logic [2:0]      r_cnt;
  logic [15:0]     r_data;
  logic            r_data_valid;
  logic            r_char_err;

  logic            w_rx;
  logic [3:0]      w_nibble;
  logic            w_is_hex;
  logic            w_is_term;

  assign w_rx       = r_rx_sync;
  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign char_err   = r_char_err;
  assign busy       = (r_state != S_IDLE);

  // Two-flop synchroniser for the asynchronous rx pin (idles high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive FSM: start qualification at half-bit, then one sample per bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_byte      <= '0;
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (!w_rx) r_state <= S_START;
        end
        S_START: begin
          if (r_timer == T_HALF) begin
            r_timer <= '0;
            if (!w_rx) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (r_timer == T_LAST) begin
            r_timer <= '0;
            r_byte  <= {w_rx, r_byte[7:1]};
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          if (r_timer == T_LAST) begin
            r_timer <= '0;
            r_state <= S_IDLE;
            if (w_rx) r_byte_done <= 1'b1;
            else      r_frame_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Classify the received byte as hex digit, line terminator or other
  always_comb begin
    w_nibble  = '0;
    w_is_hex  = 1'b0;
    w_is_term = (r_byte == 8'h0D) || (r_byte == 8'h0A);
    if (r_byte >= 8'h30 && r_byte <= 8'h39) begin
      w_nibble = r_byte[3:0];
      w_is_hex = 1'b1;
    end else if ((r_byte >= 8'h41 && r_byte <= 8'h46) ||
                 (r_byte >= 8'h61 && r_byte <= 8'h66)) begin
      w_nibble = r_byte[3:0] + 4'd9;
      w_is_hex = 1'b1;
    end
  end

  // Hex parser: shift digits in, commit on terminator, flag anything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr         <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_char_err   <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_char_err   <= 1'b0;
      if (r_byte_done) begin
        if (w_is_hex) begin
          r_sr <= {r_sr[11:0], w_nibble};
          if (r_cnt != 3'd4) r_cnt <= r_cnt + 3'd1;
        end else if (w_is_term) begin
          if (r_cnt != 3'd0) begin
            r_data       <= r_sr;
            r_data_valid <= 1'b1;
          end
          r_sr  <= '0;
          r_cnt <= '0;
        end else begin
          r_char_err <= 1'b1;
          r_sr       <= '0;
          r_cnt      <= '0;
        end
      end
    end
  end

endmodule
